// File: rtl/rt_ibex_pcs_ctx_stack_pkg.sv
// Shared constants and FSM state encoding for the interrupt context stack.
package rt_ibex_pcs_pkg;

    localparam int DefNrSavedRegs = 9;
    localparam int DefDataWidth   = 32;
    localparam int DefDepth       = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STORE   = 2'd1,
        ST_RESTORE = 2'd2,
        ST_RETURN  = 2'd3
    } ctx_state_e;

endpackage

// File: rtl/rt_ibex_pcs_ctx_stack_if.sv
// Bus between the core and the context stack; state_o exposes the FSM for debug.
interface rt_ibex_pcs_ctx_stack_if
    import rt_ibex_pcs_pkg::*;
#(
    parameter int NrSavedRegs = DefNrSavedRegs,
    parameter int DataWidth   = DefDataWidth,
    parameter int Depth       = DefDepth
) ();
    localparam int LW = $clog2(Depth + 1);

    // push_i/pop_i are single-cycle requests sampled only while busy_o=0;
    // a request seen while busy_o=1 is dropped, never queued.
    logic                                       push_i;
    logic                                       pop_i;
    logic [NrSavedRegs-1:0][DataWidth-1:0]      store_data_i;
    logic                                       err_clr_i;
    logic [NrSavedRegs-1:0][DataWidth-1:0]      restore_data_o;
    logic                                       restore_valid_o;
    logic                                       busy_o;
    logic [LW-1:0]                              level_o;
    logic                                       full_o;
    logic                                       empty_o;
    logic                                       overflow_o;
    logic                                       underflow_o;
    ctx_state_e                                 state_o;

    modport master (
        output push_i, pop_i, store_data_i, err_clr_i,
        input  restore_data_o, restore_valid_o, busy_o, level_o,
               full_o, empty_o, overflow_o, underflow_o, state_o
    );

    modport slave (
        input  push_i, pop_i, store_data_i, err_clr_i,
        output restore_data_o, restore_valid_o, busy_o, level_o,
               full_o, empty_o, overflow_o, underflow_o, state_o
    );

endinterface

// File: rtl/rt_ibex_pcs_ctx_mem.sv
// Context storage: flop array, one write port with clear, one combinational read port.
module rt_ibex_pcs_ctx_mem
    import rt_ibex_pcs_pkg::*;
#(
    parameter int NrSavedRegs = DefNrSavedRegs,
    parameter int DataWidth   = DefDataWidth,
    parameter int Depth       = DefDepth,
    parameter int AW          = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  we,
    input  logic                                  clr,
    input  logic [AW-1:0]                         waddr,
    input  logic [NrSavedRegs-1:0][DataWidth-1:0] wdata,
    input  logic [AW-1:0]                         raddr,
    output logic [NrSavedRegs-1:0][DataWidth-1:0] rdata
);
    // Storage is deliberately unreset; level tracking decides what is live.
    logic [NrSavedRegs-1:0][DataWidth-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= clr ? '0 : wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rt_ibex_pcs_ctx_stack.sv
// LIFO of saved register contexts for nested interrupts.
// Optional build macro RT_IBEX_PCS_SCRUB_EN zeroes each entry as it is popped.
module rt_ibex_pcs_ctx_stack
    import rt_ibex_pcs_pkg::*;
#(
    parameter int NrSavedRegs = DefNrSavedRegs,
    parameter int DataWidth   = DefDataWidth,
    parameter int Depth       = DefDepth
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    rt_ibex_pcs_ctx_stack_if.slave  bus
);
    localparam int LW = $clog2(Depth + 1);
    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

    ctx_state_e state_q, state_d;
    logic [LW-1:0] level_q;
    logic [NrSavedRegs-1:0][DataWidth-1:0] restore_data_q, rdata;
    logic overflow_q, underflow_q;
    logic full, empty;
    logic do_push, do_load, do_dec, set_ovf, set_unf, scrub;
    logic mem_we;
    logic [AW-1:0] push_addr, top_addr, mem_waddr;

    assign full      = (level_q == LW'(Depth));
    assign empty     = (level_q == '0);
    assign push_addr = level_q[AW-1:0];
    // Only used while level >= 1, so the wrap at level 0 is never observed.
    assign top_addr  = level_q[AW-1:0] - AW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.push_i && !full) begin
                    state_d = ST_STORE;
                end else if (bus.pop_i && !bus.push_i && !empty) begin
                    state_d = ST_RESTORE;
                end
            end
            ST_STORE:   state_d = ST_IDLE;
            ST_RESTORE: state_d = ST_RETURN;
            ST_RETURN:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // A simultaneous push and pop resolves to the push; the pop is dropped.
    always_comb begin
        do_push = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        do_load = 1'b0;
        do_dec  = 1'b0;
        scrub   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                do_push = bus.push_i && !full;
                set_ovf = bus.push_i && full;
                set_unf = bus.pop_i && !bus.push_i && empty;
            end
            ST_RESTORE: do_load = 1'b1;
            ST_RETURN: begin
                do_dec = 1'b1;
`ifdef RT_IBEX_PCS_SCRUB_EN
                scrub  = 1'b1;
`else
                scrub  = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    assign mem_we    = do_push || scrub;
    assign mem_waddr = scrub ? top_addr : push_addr;

    rt_ibex_pcs_ctx_mem #(
        .NrSavedRegs (NrSavedRegs),
        .DataWidth   (DataWidth),
        .Depth       (Depth),
        .AW          (AW)
    ) u_mem (
        .clk_i (clk_i),
        .we    (mem_we),
        .clr   (scrub),
        .waddr (mem_waddr),
        .wdata (bus.store_data_i),
        .raddr (top_addr),
        .rdata (rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q        <= '0;
            restore_data_q <= '0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            if (do_push) begin
                level_q <= level_q + LW'(1);
            end else if (do_dec) begin
                level_q <= level_q - LW'(1);
            end
            if (do_load) begin
                restore_data_q <= rdata;
            end
            // A new error in the same cycle as a clear keeps the flag set.
            overflow_q  <= set_ovf || (overflow_q && !bus.err_clr_i);
            underflow_q <= set_unf || (underflow_q && !bus.err_clr_i);
        end
    end

    assign bus.restore_data_o  = restore_data_q;
    assign bus.restore_valid_o = (state_q == ST_RETURN);
    assign bus.busy_o          = (state_q != ST_IDLE);
    assign bus.level_o         = level_q;
    assign bus.full_o          = full;
    assign bus.empty_o         = empty;
    assign bus.overflow_o      = overflow_q;
    assign bus.underflow_o     = underflow_q;
    assign bus.state_o         = state_q;

endmodule

// File: doc/rt_ibex_pcs_ctx_stack.md
RT_IBEX_PCS_CTX_STACK -- requirements
Module: rt_ibex_pcs_ctx_stack

Interface
REQ-001 SHALL have parameter NrSavedRegs, default 9, number of saved registers per context.
REQ-002 SHALL have parameter DataWidth, default 32, bits per saved register.
REQ-003 SHALL have parameter Depth, default 8, maximum nested contexts (>=2).
REQ-004 SHALL have port clk_i  input  1  clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port push_i  input  1  interrupt acknowledge; save context.
REQ-007 SHALL have port pop_i  input  1  mret pending; restore context.
REQ-008 SHALL have port store_data_i  input  NrSavedRegs x DataWidth  context to save.
REQ-009 SHALL have port err_clr_i  input  1  clears sticky error flags.
REQ-010 SHALL have port restore_data_o  output  NrSavedRegs x DataWidth  restored context, registered.
REQ-011 SHALL have port restore_valid_o  output  1  restore_data_o valid, one-cycle pulse.
REQ-012 SHALL have port busy_o  output  1  FSM not IDLE; push_i/pop_i ignored.
REQ-013 SHALL have port level_o  output  $clog2(Depth+1)  stored context count.
REQ-014 SHALL have ports full_o, empty_o  output  1 each  level_o==Depth, level_o==0.
REQ-015 SHALL have ports overflow_o, underflow_o  output  1 each  sticky error flags.

Function
REQ-016 SHALL implement FSM states IDLE, STORE, RESTORE, RETURN; all non-IDLE states last exactly one cycle.
REQ-017 IDLE with push_i=1 and full_o=0 SHALL write store_data_i into entry level_o on that edge, increment level_o, and go to STORE.
REQ-018 STORE SHALL return to IDLE; busy_o=1 for that cycle; push latency 1 cycle, next op accepted 2 cycles after push.
REQ-019 IDLE with pop_i=1, push_i=0, empty_o=0 SHALL go to RESTORE; RESTORE SHALL load entry level_o-1 into restore_data_o and go to RETURN.
REQ-020 RETURN SHALL assert restore_valid_o for one cycle, decrement level_o at its end, and go to IDLE; restore_data_o holds until the next restore.
REQ-021 Simultaneous push_i and pop_i in IDLE SHALL perform the push only; the pop is dropped and must be re-asserted.
REQ-022 push_i while full_o=1 in IDLE SHALL set overflow_o, leave storage and level_o unchanged, and stay IDLE.
REQ-023 pop_i while empty_o=1 in IDLE SHALL set underflow_o, keep restore_valid_o=0, and stay IDLE.
REQ-024 err_clr_i SHALL clear both sticky flags; a same-cycle new error SHALL win over the clear.
REQ-025 push_i/pop_i SHALL be ignored while busy_o=1 and SHALL NOT set error flags.
REQ-026 Data SHALL be strict LIFO: the Nth restore returns the context of the Nth-most-recent unrestored push.

Reset
REQ-027 Reset SHALL force IDLE, level_o=0, empty_o=1, full_o=0, busy_o=0, restore_valid_o=0, overflow_o=0, underflow_o=0, restore_data_o=0.
REQ-028 Reset mid-operation SHALL abort it immediately; storage array contents need no reset; no state is retained.

Configuration
REQ-029 With RT_IBEX_PCS_SCRUB_EN defined, RETURN SHALL zero the popped entry; without it, popped entries SHALL keep stale data. Interface and timing are identical either way.

Structure
REQ-030 Package rt_ibex_pcs_pkg SHALL hold the FSM state enum and the default NrSavedRegs, DataWidth and Depth constants.
REQ-031 Storage SHALL be a sub-module rt_ibex_pcs_ctx_mem: flop array, one write port (with clear) and one read port, addressed by level pointer, with no shift chain.

Verification
REQ-032 Reset, push A, B, C, then pop x3 -> restore_data_o=C, B, A, each with a one-cycle restore_valid_o; level_o 3->0.
REQ-033 Depth=8: 8 pushes -> full_o=1; 9th push -> overflow_o=1, level_o=8; pops return all 8 intact.
REQ-034 pop_i at reset -> underflow_o=1, restore_valid_o=0; err_clr_i -> underflow_o=0.
REQ-035 push_i+pop_i same cycle with level 1 -> level_o=2, no restore; the following pop returns the new context.
REQ-036 Assert rst_ni low during RESTORE with level 2 -> all outputs at reset values next cycle; no restore_valid_o pulse.
REQ-037 With RT_IBEX_PCS_SCRUB_EN, push 0xDEADBEEF then pop -> mem entry 0 reads 0; without the macro it reads 0xDEADBEEF.
